husky_req_sched: RTL and testbench
==================================

# husky_req_sched

Round-robin scheduler that shares the single HuskyLens request engine between several command requesters: button-triggered knock, periodic arrow polling, and future users. It sits between the requesters and the engine's start/cmd/data_len/done handshake. It serialises transactions, holds `req_husky_start` until the engine reports done, enforces an inter-transaction gap, and aborts with a timeout if the engine never completes.

## Interface
- `NUM_REQ`, 3: number of requester ports (2..8).
- `GAP_CYC`, 16: idle cycles forced between consecutive transactions (≥1).
- `TIMEOUT_CYC`, 1_000_000: maximum cycles a transaction may wait for done (≥2).
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in NUM_REQ: per-requester request, level, held until `req_ack` or `req_timeout`.
- `req_cmd` in 8*NUM_REQ: packed command bytes; requester i at [8i+7:8i].
- `req_len` in 8*NUM_REQ: packed data-length bytes, same packing.
- `req_ack` out NUM_REQ: one-cycle pulse to owner on engine completion.
- `req_timeout` out NUM_REQ: one-cycle pulse to owner on abort.
- `req_husky_start` out 1: to engine; level-high for the whole transaction.
- `req_husky_cmd` out 8: to engine; stable while start is high.
- `req_husky_data_len` out 8: to engine; stable while start is high.
- `req_husky_done` in 1: from engine; completion pulse.
- `busy` out 1: high outside IDLE.
- `owner` out $clog2(NUM_REQ): index of current/last granted requester.
- `err_timeout` out 1: sticky, set on any timeout, cleared only by `rst`.

## Operation
- States: IDLE, BUSY, GAP.
- IDLE:
  - If any `req_valid` is set, pick the winner round-robin, starting the search at `rr_ptr` and wrapping.
  - Register the winner's cmd/len into `req_husky_cmd`/`req_husky_data_len`, set `req_husky_start`, load `owner`, clear `to_cnt`, go to BUSY.
- BUSY:
  - `to_cnt` increments each cycle.
  - On `req_husky_done`: clear start, set cmd to CMD_NONE (0x00) and len to 0x00, pulse `req_ack[owner]`, set `rr_ptr` = owner+1 mod NUM_REQ, load `gap_cnt`, go to GAP.
  - Else, when `to_cnt` == TIMEOUT_CYC-1: same clearing, pulse `req_timeout[owner]`, set `err_timeout`, advance `rr_ptr`, go to GAP.
  - done and the timeout limit in the same cycle: done wins, no timeout pulse.
  - Owner dropping `req_valid` mid-transaction: ignored; transaction completes and ack still pulses.
- GAP:
  - Count GAP_CYC cycles, then go to IDLE.
  - `req_valid` is not sampled in GAP.
- `req_husky_done` in IDLE or GAP is ignored.
- Requesters must see their ack/timeout and deassert `req_valid` within GAP_CYC cycles. Otherwise they are re-granted, which is legal.
- Counter widths: `to_cnt` is $clog2(TIMEOUT_CYC+1) bits; `gap_cnt` is $clog2(GAP_CYC+1) bits. Neither counter wraps; both saturate at the compare value.

## Timing
- Reset values:
  - start 0, cmd 0x00, len 0x00.
  - `req_ack` 0, `req_timeout` 0.
  - `busy` 0, `owner` 0, `err_timeout` 0.
  - `rr_ptr` 0, state IDLE.
- `req_valid` seen in IDLE at cycle t → start/cmd/len valid at t+1, `busy` high at t+1.
- done at cycle d → start low, ack pulse, state GAP, all at d+1.
- Earliest next start is d+1+GAP_CYC+1.
- Timeout: start at s, no done → `req_timeout` pulse and start low at s+TIMEOUT_CYC.
- `rst` mid-transaction: all outputs return to reset values on the next edge. No ack or timeout is pulsed.
- All outputs are registered; there is no combinational path from `req_valid` or `req_husky_done` to any output.

## Structure
- Shared package `husky_pkg`:
  - CMD_NONE 8'h00, CMD_REQUEST_KNOCK 8'h2C, CMD_REQUEST_ARROW_LEARNED 8'h25.
  - State encoding (IDLE/BUSY/GAP).
- Sub-module `husky_rr_pick`: combinational round-robin picker; takes `req_valid` and `rr_ptr`, returns `any` and `idx`. It is reusable by other shared-resource arbiters.
- FSM, counters and output registers live in `husky_req_sched`.

## Test plan
Parameters for all scenarios: NUM_REQ=3, GAP_CYC=4, TIMEOUT_CYC=100.
- Single request: req 1 with cmd 0x2C, len 0 → start=1, cmd=0x2C next cycle; done after 10 cycles → ack[1] pulse, start=0, cmd=0x00, next grant no earlier than 5 cycles later.
- Round-robin: reqs 0, 1, 2 held continuously, engine returns done after 3 cycles each → grant order 0,1,2,0 with `owner` matching.
- Timeout: req 2 with cmd 0x25 and no done → at start+100, `req_timeout[2]` pulses, `err_timeout`=1 and stays 1; next grant goes to req 0.
- Done at the timeout cycle: done asserted exactly at the 100th BUSY cycle → ack pulses, no timeout pulse, `err_timeout` stays 0.
- Reset mid-BUSY: rst for 1 cycle during a transaction → start=0, cmd=0x00, `busy`=0, no ack; a fresh request is then granted to req 0 first.
- Spurious done: done pulsed in IDLE and GAP → no output change.

Source files
------------

// File: rtl/husky_pkg.sv
// Shared HuskyLens command codes and request-scheduler state encoding.
package husky_pkg;

   localparam logic [7:0] CMD_NONE                  = 8'h00;
   localparam logic [7:0] CMD_REQUEST_KNOCK         = 8'h2C;
   localparam logic [7:0] CMD_REQUEST_ARROW_LEARNED = 8'h25;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_GAP  = 2'd2
   } sched_state_t;

endpackage

// File: rtl/husky_rr_pick.sv
// Combinational round-robin picker: first set request at or after rr_ptr, wrapping.
// Zero latency; no handshake of its own, the caller owns rr_ptr.
module husky_rr_pick #(
   parameter int N = 3,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] req_valid,
   input  logic [W-1:0] rr_ptr,
   output logic         any,
   output logic [W-1:0] idx
);

   always_comb begin
      any = |req_valid;
      idx = '0;
      // Walk from the farthest offset down so the offset closest to rr_ptr wins.
      for (int k = N - 1; k >= 0; k--) begin
         int p;
         p = int'(rr_ptr) + k;
         if (p >= N) begin
            p = p - N;
         end
         if (req_valid[p]) begin
            idx = W'(p);
         end
      end
   end

endmodule

// File: rtl/husky_req_sched.sv
// Round-robin arbiter sharing the HuskyLens request engine; grant registered one cycle after req_valid.
// Start held until done or timeout, then a forced idle gap; requesters wait on req_valid until ack/timeout.
module husky_req_sched
   import husky_pkg::*;
#(
   parameter int NUM_REQ     = 3,
   parameter int GAP_CYC     = 16,
   parameter int TIMEOUT_CYC = 1_000_000,
   localparam int OW         = $clog2(NUM_REQ)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [8*NUM_REQ-1:0] req_cmd,
   input  logic [8*NUM_REQ-1:0] req_len,
   output logic [NUM_REQ-1:0]   req_ack,
   output logic [NUM_REQ-1:0]   req_timeout,
   output logic                 req_husky_start,
   output logic [7:0]           req_husky_cmd,
   output logic [7:0]           req_husky_data_len,
   input  logic                 req_husky_done,
   output logic                 busy,
   output logic [OW-1:0]        owner,
   output logic                 err_timeout
);

   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam int GW = $clog2(GAP_CYC + 1);
   localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);
   localparam logic [OW-1:0] OWN_MAX  = OW'(NUM_REQ - 1);

   sched_state_t         r_state, w_state_nxt;
   logic                 r_start, w_start_nxt;
   logic [7:0]           r_cmd, w_cmd_nxt;
   logic [7:0]           r_len, w_len_nxt;
   logic [NUM_REQ-1:0]   r_ack, w_ack_nxt;
   logic [NUM_REQ-1:0]   r_to, w_to_nxt;
   logic [OW-1:0]        r_owner, w_owner_nxt;
   logic                 r_err, w_err_nxt;
   logic [OW-1:0]        r_rr_ptr, w_rr_ptr_nxt;
   logic [TW-1:0]        r_to_cnt, w_to_cnt_nxt;
   logic [GW-1:0]        r_gap_cnt, w_gap_cnt_nxt;

   logic                 w_pick_any;
   logic [OW-1:0]        w_pick_idx;
   logic [OW-1:0]        w_ptr_adv;
   logic                 w_finish;

   husky_rr_pick #(
      .N (NUM_REQ),
      .W (OW)
   ) u_pick (
      .req_valid (req_valid),
      .rr_ptr    (r_rr_ptr),
      .any       (w_pick_any),
      .idx       (w_pick_idx)
   );

   assign w_ptr_adv = (r_owner == OWN_MAX) ? '0 : r_owner + 1'b1;
   assign w_finish  = req_husky_done || (r_to_cnt == TO_LAST);

   always_comb begin
      w_state_nxt   = r_state;
      w_start_nxt   = r_start;
      w_cmd_nxt     = r_cmd;
      w_len_nxt     = r_len;
      w_ack_nxt     = '0;
      w_to_nxt      = '0;
      w_owner_nxt   = r_owner;
      w_err_nxt     = r_err;
      w_rr_ptr_nxt  = r_rr_ptr;
      w_to_cnt_nxt  = r_to_cnt;
      w_gap_cnt_nxt = r_gap_cnt;
      case (r_state)
         ST_IDLE: begin
            if (w_pick_any) begin
               w_state_nxt  = ST_BUSY;
               w_start_nxt  = 1'b1;
               w_cmd_nxt    = req_cmd[{w_pick_idx, 3'b000} +: 8];
               w_len_nxt    = req_len[{w_pick_idx, 3'b000} +: 8];
               w_owner_nxt  = w_pick_idx;
               w_to_cnt_nxt = '0;
            end
         end
         ST_BUSY: begin
            if (r_to_cnt != TO_LAST) begin
               w_to_cnt_nxt = r_to_cnt + 1'b1;
            end
            if (w_finish) begin
               w_state_nxt   = ST_GAP;
               w_start_nxt   = 1'b0;
               w_cmd_nxt     = CMD_NONE;
               w_len_nxt     = 8'h00;
               w_rr_ptr_nxt  = w_ptr_adv;
               w_gap_cnt_nxt = '0;
               // A done arriving on the limit cycle still counts as success.
               if (req_husky_done) begin
                  w_ack_nxt[r_owner] = 1'b1;
               end else begin
                  w_to_nxt[r_owner] = 1'b1;
                  w_err_nxt         = 1'b1;
               end
            end
         end
         ST_GAP: begin
            if (r_gap_cnt == GAP_LAST) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_gap_cnt_nxt = r_gap_cnt + 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_start   <= 1'b0;
         r_cmd     <= CMD_NONE;
         r_len     <= 8'h00;
         r_ack     <= '0;
         r_to      <= '0;
         r_owner   <= '0;
         r_err     <= 1'b0;
         r_rr_ptr  <= '0;
         r_to_cnt  <= '0;
         r_gap_cnt <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_start   <= w_start_nxt;
         r_cmd     <= w_cmd_nxt;
         r_len     <= w_len_nxt;
         r_ack     <= w_ack_nxt;
         r_to      <= w_to_nxt;
         r_owner   <= w_owner_nxt;
         r_err     <= w_err_nxt;
         r_rr_ptr  <= w_rr_ptr_nxt;
         r_to_cnt  <= w_to_cnt_nxt;
         r_gap_cnt <= w_gap_cnt_nxt;
      end
   end

   assign req_husky_start    = r_start;
   assign req_husky_cmd      = r_cmd;
   assign req_husky_data_len = r_len;
   assign req_ack            = r_ack;
   assign req_timeout        = r_to;
   assign owner              = r_owner;
   assign err_timeout        = r_err;
   assign busy               = (r_state != ST_IDLE);

endmodule

// File: tb/tb_husky_req_sched.sv
// Directed and randomized transactions for husky_req_sched against a transaction-level model.
module tb_husky_req_sched;

   localparam int N   = 3;
   localparam int GAP = 4;
   localparam int TO  = 100;

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  req_valid;
   logic [8*N-1:0] req_cmd;
   logic [8*N-1:0] req_len;
   logic [N-1:0]  req_ack;
   logic [N-1:0]  req_timeout;
   logic          req_husky_start;
   logic [7:0]    req_husky_cmd;
   logic [7:0]    req_husky_data_len;
   logic          req_husky_done;
   logic          busy;
   logic [1:0]    owner;
   logic          err_timeout;

   husky_req_sched #(
      .NUM_REQ     (N),
      .GAP_CYC     (GAP),
      .TIMEOUT_CYC (TO)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .req_valid          (req_valid),
      .req_cmd            (req_cmd),
      .req_len            (req_len),
      .req_ack            (req_ack),
      .req_timeout        (req_timeout),
      .req_husky_start    (req_husky_start),
      .req_husky_cmd      (req_husky_cmd),
      .req_husky_data_len (req_husky_data_len),
      .req_husky_done     (req_husky_done),
      .busy               (busy),
      .owner              (owner),
      .err_timeout        (err_timeout)
   );

   always #5 clk = ~clk;

   int         checks = 0;
   int         errors = 0;
   logic [2:0] pend;
   logic [7:0] cmd_m [N];
   logic [7:0] len_m [N];
   int         m_ptr;
   bit         m_err;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      req_valid = pend;
      req_cmd   = {cmd_m[2], cmd_m[1], cmd_m[0]};
      req_len   = {len_m[2], len_m[1], len_m[0]};
   endtask

   // First pending requester at or after the pointer, wrapping around.
   function automatic int pick(input logic [2:0] m, input int ptr);
      for (int k = 0; k < N; k++) begin
         int i;
         i = (ptr + k) % N;
         if (m[i]) return i;
      end
      return -1;
   endfunction

   // k = cycle offset (from first start cycle) at which done is driven; k >= TO means never.
   task automatic run_txn(input logic [2:0] add, input int k, input bit keep, input bit drop_mid);
      int         w;
      int         last;
      bit         to_exp;
      logic [2:0] oh;
      pend = pend | add;
      drive();
      w  = pick(pend, m_ptr);
      oh = 3'b001 << w;
      step();
      chk("grant_start", 32'(req_husky_start), 1);
      chk("grant_busy", 32'(busy), 1);
      chk("grant_owner", 32'(owner), 32'(w));
      chk("grant_cmd", 32'(req_husky_cmd), 32'(cmd_m[w]));
      chk("grant_len", 32'(req_husky_data_len), 32'(len_m[w]));
      chk("grant_ack", 32'(req_ack), 0);
      if (drop_mid) begin
         pend[w] = 1'b0;
         drive();
      end
      to_exp = (k > TO - 1);
      last   = to_exp ? TO - 1 : k;
      for (int j = 0; j <= last; j++) begin
         req_husky_done = (j == k);
         step();
         if (j < last) begin
            chk("hold_start", 32'(req_husky_start), 1);
            chk("hold_cmd", 32'(req_husky_cmd), 32'(cmd_m[w]));
            chk("hold_ack_to", 32'({req_ack, req_timeout}), 0);
         end
      end
      req_husky_done = 1'b0;
      if (to_exp) m_err = 1'b1;
      m_ptr = (w + 1) % N;
      chk("end_start", 32'(req_husky_start), 0);
      chk("end_cmd", 32'(req_husky_cmd), 0);
      chk("end_len", 32'(req_husky_data_len), 0);
      chk("end_busy", 32'(busy), 1);
      chk("end_owner", 32'(owner), 32'(w));
      chk("end_ack", 32'(req_ack), to_exp ? 32'd0 : 32'(oh));
      chk("end_timeout", 32'(req_timeout), to_exp ? 32'(oh) : 32'd0);
      chk("end_err", 32'(err_timeout), 32'(m_err));
      if (!keep) pend[w] = 1'b0;
      drive();
      for (int g = 1; g <= GAP; g++) begin
         req_husky_done = ($urandom_range(0, 2) == 0);
         step();
         chk("gap_start", 32'(req_husky_start), 0);
         chk("gap_ack_to", 32'({req_ack, req_timeout}), 0);
         chk("gap_busy", 32'(busy), (g < GAP) ? 32'd1 : 32'd0);
         chk("gap_owner", 32'(owner), 32'(w));
         chk("gap_err", 32'(err_timeout), 32'(m_err));
      end
      req_husky_done = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      req_husky_done = 1'b0;
      pend = '0;
      for (int i = 0; i < N; i++) begin
         cmd_m[i] = 8'h00;
         len_m[i] = 8'h00;
      end
      m_ptr = 0;
      m_err = 1'b0;
      drive();
      repeat (3) step();
      chk("rst_start", 32'(req_husky_start), 0);
      chk("rst_cmd", 32'(req_husky_cmd), 0);
      chk("rst_len", 32'(req_husky_data_len), 0);
      chk("rst_ack_to", 32'({req_ack, req_timeout}), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_owner", 32'(owner), 0);
      chk("rst_err", 32'(err_timeout), 0);
      rst = 1'b0;
      step();

      // Done while idle must not disturb anything.
      for (int i = 0; i < 3; i++) begin
         req_husky_done = 1'b1;
         step();
         chk("idle_done_start", 32'(req_husky_start), 0);
         chk("idle_done_busy", 32'(busy), 0);
         chk("idle_done_ack", 32'(req_ack), 0);
      end
      req_husky_done = 1'b0;

      // Round-robin with all three held: expect owners 0,1,2,0.
      cmd_m[0] = 8'h11; len_m[0] = 8'h01;
      cmd_m[1] = 8'h2C; len_m[1] = 8'h02;
      cmd_m[2] = 8'h25; len_m[2] = 8'h03;
      run_txn(3'b111, 2, 1'b1, 1'b0);
      chk("rr_ptr_after0", 32'(pick(3'b111, m_ptr)), 1);
      run_txn(3'b000, 2, 1'b1, 1'b0);
      run_txn(3'b000, 2, 1'b1, 1'b0);
      run_txn(3'b000, 2, 1'b0, 1'b0);

      // Single knock request from requester 1.
      pend = '0;
      cmd_m[1] = 8'h2C; len_m[1] = 8'h00;
      run_txn(3'b010, 9, 1'b0, 1'b0);

      // Done on the last allowed BUSY cycle; requester also drops valid mid-transaction.
      pend = '0;
      run_txn(3'b001, TO - 1, 1'b0, 1'b1);

      // No done at all from requester 2: timeout.
      pend = '0;
      cmd_m[2] = 8'h25; len_m[2] = 8'h00;
      run_txn(3'b100, 200, 1'b0, 1'b0);
      chk("timeout_sticky", 32'(err_timeout), 1);
      run_txn(3'b111, 1, 1'b0, 1'b0);

      // Reset in the middle of a transaction.
      drive();
      step();
      chk("mid_grant_owner", 32'(owner), 32'(pick(pend, m_ptr)));
      chk("mid_grant_start", 32'(req_husky_start), 1);
      repeat (3) step();
      rst  = 1'b1;
      pend = '0;
      drive();
      step();
      m_ptr = 0;
      m_err = 1'b0;
      chk("midrst_start", 32'(req_husky_start), 0);
      chk("midrst_cmd", 32'(req_husky_cmd), 0);
      chk("midrst_len", 32'(req_husky_data_len), 0);
      chk("midrst_busy", 32'(busy), 0);
      chk("midrst_ack_to", 32'({req_ack, req_timeout}), 0);
      chk("midrst_owner", 32'(owner), 0);
      chk("midrst_err", 32'(err_timeout), 0);
      rst = 1'b0;
      run_txn(3'b111, 3, 1'b0, 1'b0);

      // Randomized traffic.
      for (int t = 0; t < 30; t++) begin
         logic [2:0] add;
         int         r;
         int         k;
         add = 3'($urandom_range(0, 7));
         if ((pend | add) == 3'b000) add = 3'b001 << $urandom_range(0, 2);
         for (int i = 0; i < N; i++) begin
            cmd_m[i] = 8'($urandom_range(0, 255));
            len_m[i] = 8'($urandom_range(0, 255));
         end
         r = $urandom_range(0, 9);
         if (r < 7)       k = $urandom_range(0, 12);
         else if (r == 7) k = TO - 1;
         else if (r == 8) k = TO - 2;
         else             k = $urandom_range(TO, TO + 30);
         run_txn(add, k, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
